// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter: ping-pong frame buffer arbiter for camera writes and
// display reads, one AXI burst outstanding at a time, round-robin on ties.
// Ports:
//   ACLK, ARESETN              clock, async active-low reset
//   wr_fifo_cnt, rd_fifo_cnt   camera / display FIFO levels in beats
//   rd_en                      display path enable
//   WR_READY/DONE, RD_READY/DONE  AXI master idle / burst-complete pulse
//   WR_START/ADRS/LEN, RD_START/ADRS/LEN  burst trigger, byte addr, beats
//   wr_frame_done, rd_frame_done  pulse after the last burst of a frame
module ddr3_rw_arbiter #(
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned FRAME_BYTES   = 614400,
  parameter logic [31:0] BANK0_ADDR    = 32'h0000_0000,
  parameter logic [31:0] BANK1_ADDR    = 32'h0010_0000,
  parameter int unsigned RD_FIFO_DEPTH = 512
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [9:0]  wr_fifo_cnt,
  input  logic [9:0]  rd_fifo_cnt,
  input  logic        rd_en,
  input  logic        WR_READY,
  input  logic        WR_DONE,
  input  logic        RD_READY,
  input  logic        RD_DONE,
  output logic        WR_START,
  output logic        RD_START,
  output logic [31:0] WR_ADRS,
  output logic [31:0] RD_ADRS,
  output logic [9:0]  WR_LEN,
  output logic [9:0]  RD_LEN,
  output logic        wr_frame_done,
  output logic        rd_frame_done
);

  localparam logic [31:0] BL    = 32'(BURST_LEN);
  localparam logic [31:0] STEP  = 32'(BURST_LEN * 8);
  localparam logic [31:0] FB    = 32'(FRAME_BYTES);
  localparam logic [31:0] RD_TH = 32'(RD_FIFO_DEPTH - BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    WR_BUSY,
    RD_BUSY
  } state_t;

  state_t      state_q, state_d;
  logic        last_rd_q;
  logic        wr_ok, rd_ok;
  logic        wr_gnt, rd_gnt;
  logic        wr_fin, rd_fin;
  logic        wr_wrap, rd_wrap;
  logic [31:0] wr_sum, rd_sum;
  logic [31:0] wr_ptr_q, wr_ptr_d;
  logic [31:0] rd_ptr_q, rd_ptr_d;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;

  assign WR_LEN = 10'(BURST_LEN);
  assign RD_LEN = 10'(BURST_LEN);

  assign wr_ok = ({22'd0, wr_fifo_cnt} >= BL)
              && WR_READY;
  assign rd_ok = rd_en
              && ({22'd0, rd_fifo_cnt} <= RD_TH)
              && RD_READY;

  // last_rd_q=1 means read had the last grant,
  // so write wins a tie.
  always_comb begin
    state_d = state_q;
    wr_gnt  = 1'b0;
    rd_gnt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_ok && (!rd_ok || last_rd_q)) begin
          wr_gnt  = 1'b1;
          state_d = WR_BUSY;
        end else if (rd_ok) begin
          rd_gnt  = 1'b1;
          state_d = RD_BUSY;
        end
      end
      WR_BUSY: if (WR_DONE) state_d = IDLE;
      RD_BUSY: if (RD_DONE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_fin  = (state_q == WR_BUSY) && WR_DONE;
  assign rd_fin  = (state_q == RD_BUSY) && RD_DONE;
  assign wr_sum  = wr_ptr_q + STEP;
  assign rd_sum  = rd_ptr_q + STEP;
  assign wr_wrap = wr_fin && (wr_sum == FB);
  assign rd_wrap = rd_fin && (rd_sum == FB);

  // Reads follow the bank the writer just finished,
  // using the post-toggle write bank.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_bank_d = wr_bank_q ^ wr_wrap;
    rd_bank_d = rd_bank_q;
    if (wr_fin)
      wr_ptr_d = wr_wrap ? 32'd0 : wr_sum;
    if (rd_fin)
      rd_ptr_d = rd_wrap ? 32'd0 : rd_sum;
    else if (!rd_en && state_q != RD_BUSY)
      rd_ptr_d = 32'd0;
    if (rd_wrap)
      rd_bank_d = ~wr_bank_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      last_rd_q     <= 1'b1;
      wr_ptr_q      <= 32'd0;
      rd_ptr_q      <= 32'd0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      WR_START      <= 1'b0;
      RD_START      <= 1'b0;
      wr_frame_done <= 1'b0;
      rd_frame_done <= 1'b0;
      WR_ADRS       <= BANK0_ADDR;
      RD_ADRS       <= BANK1_ADDR;
    end else begin
      state_q       <= state_d;
      if (wr_gnt) last_rd_q <= 1'b0;
      if (rd_gnt) last_rd_q <= 1'b1;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      WR_START      <= wr_gnt;
      RD_START      <= rd_gnt;
      wr_frame_done <= wr_wrap;
      rd_frame_done <= rd_wrap;
      WR_ADRS       <= (wr_bank_d ? BANK1_ADDR
                                  : BANK0_ADDR) + wr_ptr_d;
      RD_ADRS       <= (rd_bank_d ? BANK1_ADDR
                                  : BANK0_ADDR) + rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// tb_ddr3_rw_arbiter: directed bench with an AXI master responder and a
// scoreboard of expected burst starts (kind + address).
module tb_ddr3_rw_arbiter;

  logic        ACLK;
  logic        ARESETN;
  logic [9:0]  wr_fifo_cnt;
  logic [9:0]  rd_fifo_cnt;
  logic        rd_en;
  logic        WR_READY = 1'b1;
  logic        WR_DONE  = 1'b0;
  logic        RD_READY = 1'b1;
  logic        RD_DONE  = 1'b0;
  logic        WR_START, RD_START;
  logic [31:0] WR_ADRS, RD_ADRS;
  logic [9:0]  WR_LEN, RD_LEN;
  logic        wr_frame_done, rd_frame_done;

  typedef struct packed {
    logic        wr;
    logic [31:0] adrs;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   wr_starts = 0, rd_starts = 0;
  int   wr_fd_cnt = 0, rd_fd_cnt = 0;
  int   wr_fd_at = 0, rd_fd_at = 0;
  bit   outstanding = 0;
  int   lat = 2;
  int   wr_cnt = 0, rd_cnt = 0;
  bit   stray_wr = 0;
  int   wbase, rbase, fdw, fdr;

  ddr3_rw_arbiter dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .wr_fifo_cnt   (wr_fifo_cnt),
    .rd_fifo_cnt   (rd_fifo_cnt),
    .rd_en         (rd_en),
    .WR_READY      (WR_READY),
    .WR_DONE       (WR_DONE),
    .RD_READY      (RD_READY),
    .RD_DONE       (RD_DONE),
    .WR_START      (WR_START),
    .RD_START      (RD_START),
    .WR_ADRS       (WR_ADRS),
    .RD_ADRS       (RD_ADRS),
    .WR_LEN        (WR_LEN),
    .RD_LEN        (RD_LEN),
    .wr_frame_done (wr_frame_done),
    .rd_frame_done (rd_frame_done)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [31:0] a);
    exp_t e;
    e.wr   = wr;
    e.adrs = a;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge ACLK);
    #3;
  endtask

  function automatic bit bus_idle();
    return wr_cnt == 0 && rd_cnt == 0
        && !WR_DONE && !RD_DONE
        && !WR_START && !RD_START;
  endfunction

  task automatic wait_idle(input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      step();
      if (bus_idle()) begin
        ok = 1;
        break;
      end
    end
    check("wait_idle", 32'(ok), 32'd1);
  endtask

  task automatic run_bursts(input int nw, input int nr,
                            input int max);
    int tw, tr;
    bit ok;
    tw = wr_starts + nw;
    tr = rd_starts + nr;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (wr_starts >= tw) wr_fifo_cnt = 10'd0;
      if (rd_starts >= tr) rd_fifo_cnt = 10'd511;
      if (wr_starts >= tw && rd_starts >= tr
          && bus_idle()) begin
        ok = 1;
        break;
      end
      step();
    end
    check("run_bursts_done", 32'(ok), 32'd1);
  endtask

  // AXI master model: drops READY on START, pulses DONE after lat cycles.
  always @(posedge ACLK) begin
    #2;
    WR_DONE = 1'b0;
    RD_DONE = 1'b0;
    if (!ARESETN) begin
      wr_cnt   = 0;
      rd_cnt   = 0;
      WR_READY = 1'b1;
      RD_READY = 1'b1;
    end else begin
      if (WR_START) begin
        WR_READY = 1'b0;
        wr_cnt   = lat;
      end else if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) begin
          WR_DONE  = 1'b1;
          WR_READY = 1'b1;
        end
      end
      if (RD_START) begin
        RD_READY = 1'b0;
        rd_cnt   = lat;
      end else if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          RD_DONE  = 1'b1;
          RD_READY = 1'b1;
        end
      end
      if (stray_wr) WR_DONE = 1'b1;
    end
  end

  // Scoreboard monitor.
  always @(posedge ACLK) begin
    #1;
    if (!ARESETN) begin
      outstanding = 0;
    end else begin
      if (WR_DONE || RD_DONE) outstanding = 0;
      if (wr_frame_done) begin
        wr_fd_cnt++;
        wr_fd_at = wr_starts;
      end
      if (rd_frame_done) begin
        rd_fd_cnt++;
        rd_fd_at = rd_starts;
      end
      if (WR_START || RD_START) begin
        check("single_start",
              32'(WR_START & RD_START), 32'd0);
        check("one_outstanding",
              32'(outstanding), 32'd0);
        outstanding = 1;
        if (WR_START) wr_starts++;
        else rd_starts++;
        check("start_expected",
              32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("start_kind",
                32'(WR_START), 32'(mon_e.wr));
          check("start_adrs",
                WR_START ? WR_ADRS : RD_ADRS,
                mon_e.adrs);
          check("start_len",
                WR_START ? 32'(WR_LEN) : 32'(RD_LEN),
                32'd64);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN     = 1'b1;
    wr_fifo_cnt = 10'd0;
    rd_fifo_cnt = 10'd511;
    rd_en       = 1'b0;
    #1 ARESETN  = 1'b0;
    step();
    step();
    check("rst_wr_start", 32'(WR_START), 32'd0);
    check("rst_rd_start", 32'(RD_START), 32'd0);
    check("rst_wr_adrs", WR_ADRS, 32'h0000_0000);
    check("rst_rd_adrs", RD_ADRS, 32'h0010_0000);
    check("rst_wr_len", 32'(WR_LEN), 32'd64);
    check("rst_rd_len", 32'(RD_LEN), 32'd64);
    check("rst_wr_fd", 32'(wr_frame_done), 32'd0);
    check("rst_rd_fd", 32'(rd_frame_done), 32'd0);
    ARESETN = 1'b1;
    step();

    // single write burst
    push(1'b1, 32'h0);
    wr_fifo_cnt = 10'd64;
    step();
    check("wr_start_lat", 32'(WR_START), 32'd1);
    check("wr_adrs0", WR_ADRS, 32'h0);
    wr_fifo_cnt = 10'd0;
    wait_idle(50);
    check("wr_adrs_next", WR_ADRS, 32'h200);

    // DONE while idle must be ignored
    stray_wr = 1;
    step();
    stray_wr = 0;
    step();
    step();
    check("stray_done_ignored", WR_ADRS, 32'h200);
    check("stray_no_fd", 32'(wr_fd_cnt), 32'd0);

    // read threshold
    rd_en       = 1'b1;
    rd_fifo_cnt = 10'd449;
    repeat (6) step();
    check("rd_blocked_449", 32'(rd_starts), 32'd0);
    push(1'b0, 32'h0010_0000);
    rd_fifo_cnt = 10'd448;
    step();
    check("rd_start_448", 32'(RD_START), 32'd1);
    rd_fifo_cnt = 10'd511;
    wait_idle(50);
    check("rd_adrs_next", RD_ADRS, 32'h0010_0200);

    // rd_en dropped during an in-flight read
    lat = 6;
    push(1'b0, 32'h0010_0200);
    rd_fifo_cnt = 10'd448;
    step();
    check("rd_start_2", 32'(RD_START), 32'd1);
    rd_en       = 1'b0;
    rd_fifo_cnt = 10'd511;
    step();
    step();
    check("rd_adrs_inflight", RD_ADRS, 32'h0010_0200);
    wait_idle(50);
    check("rd_adrs_done", RD_ADRS, 32'h0010_0400);
    step();
    check("rd_ptr_cleared", RD_ADRS, 32'h0010_0000);
    lat = 2;

    // both pending: last grant was read, so W,R,W,R
    push(1'b1, 32'h200);
    push(1'b0, 32'h0010_0000);
    push(1'b1, 32'h400);
    push(1'b0, 32'h0010_0200);
    rd_en       = 1'b1;
    rd_fifo_cnt = 10'd0;
    wr_fifo_cnt = 10'd64;
    run_bursts(2, 2, 200);
    check("alt_q_empty", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a write burst
    lat   = 20;
    rd_en = 1'b0;
    push(1'b1, 32'h600);
    wr_fifo_cnt = 10'd64;
    step();
    check("wr_start_pre_rst", 32'(WR_START), 32'd1);
    wr_fifo_cnt = 10'd0;
    step();
    step();
    ARESETN = 1'b0;
    #1;
    check("mid_rst_wr_start", 32'(WR_START), 32'd0);
    check("mid_rst_rd_start", 32'(RD_START), 32'd0);
    check("mid_rst_wr_adrs", WR_ADRS, 32'h0);
    check("mid_rst_rd_adrs", RD_ADRS, 32'h0010_0000);
    step();
    ARESETN = 1'b1;
    lat = 1;
    step();

    // full write frame: 1200 bursts, then bank 1
    wbase = wr_starts;
    fdw   = wr_fd_cnt;
    for (int i = 0; i < 1200; i++)
      push(1'b1, 32'(i) * 32'h200);
    push(1'b1, 32'h0010_0000);
    wr_fifo_cnt = 10'd64;
    step();
    check("wr_start_post_rst", 32'(WR_START), 32'd1);
    run_bursts(1200, 0, 6000);
    check("wr_fd_pulses", 32'(wr_fd_cnt - fdw), 32'd1);
    check("wr_fd_on_1200", 32'(wr_fd_at - wbase), 32'd1200);
    check("wr_bank1_adrs", WR_ADRS, 32'h0010_0200);

    // full read frame from bank 1, wraps to bank ~wr_bank = 0
    rbase = rd_starts;
    fdr   = rd_fd_cnt;
    for (int i = 0; i < 1200; i++)
      push(1'b0, 32'h0010_0000 + 32'(i) * 32'h200);
    push(1'b0, 32'h0);
    rd_en       = 1'b1;
    rd_fifo_cnt = 10'd0;
    run_bursts(0, 1201, 6000);
    check("rd_fd_pulses", 32'(rd_fd_cnt - fdr), 32'd1);
    check("rd_fd_on_1200", 32'(rd_fd_at - rbase), 32'd1200);
    check("rd_bank0_adrs", RD_ADRS, 32'h200);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr3_rw_arbiter.md
DDR3_RW_ARBITER -- requirements
Module: ddr3_rw_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 64, meaning 64-bit beats per burst (legal range 1..256).
REQ-002 SHALL have parameter FRAME_BYTES, default 614400, meaning bytes per frame (multiple of BURST_LEN*8).
REQ-003 SHALL have parameter BANK0_ADDR, default 32'h0000_0000, meaning frame bank 0 base byte address.
REQ-004 SHALL have parameter BANK1_ADDR, default 32'h0010_0000, meaning frame bank 1 base byte address.
REQ-005 SHALL have parameter RD_FIFO_DEPTH, default 512, meaning read FIFO depth in beats.
REQ-006 SHALL have port ACLK  in  1  clock; reset ARESETN, asynchronous, active-low; clock ACLK.
REQ-007 SHALL have port ARESETN  in  1  asynchronous active-low reset.
REQ-008 SHALL have port wr_fifo_cnt  in  10  beats available in the write (camera) FIFO.
REQ-009 SHALL have port rd_fifo_cnt  in  10  beats currently held in the read (display) FIFO.
REQ-010 SHALL have port rd_en  in  1  read path enable (display ready).
REQ-011 SHALL have port WR_READY / WR_DONE  in  1 each  AXI write master idle / burst-complete pulse.
REQ-012 SHALL have port RD_READY / RD_DONE  in  1 each  AXI read master idle / burst-complete pulse.
REQ-013 SHALL have port WR_START / RD_START  out  1 each  single-cycle burst trigger.
REQ-014 SHALL have port WR_ADRS / RD_ADRS  out  32 each  burst start byte address.
REQ-015 SHALL have port WR_LEN / RD_LEN  out  10 each  burst length in beats, constant BURST_LEN.
REQ-016 SHALL have port wr_frame_done / rd_frame_done  out  1 each  single-cycle pulse on last burst of a frame.

Function
REQ-017 SHALL implement states IDLE, WR_BUSY, RD_BUSY; only one burst outstanding at any time.
REQ-018 Write request SHALL be wr_fifo_cnt >= BURST_LEN.
REQ-019 Read request SHALL be rd_en=1 and rd_fifo_cnt <= RD_FIFO_DEPTH-BURST_LEN.
REQ-020 IDLE SHALL grant a request only if the matching READY=1; ungranted requests keep waiting.
REQ-021 When both requests are grantable, SHALL grant the side not granted last (round-robin, last_grant reset = read, so write wins first tie).
REQ-022 On grant, SHALL enter WR_BUSY/RD_BUSY and assert WR_START/RD_START for exactly the first cycle of that state (1 cycle after the request was sampled in IDLE).
REQ-023 ADRS SHALL be bank_base + ptr, stable from START until DONE; LEN SHALL equal BURST_LEN always.
REQ-024 BUSY SHALL return to IDLE the cycle after DONE is sampled; DONE in any other state SHALL be ignored.
REQ-025 On DONE, ptr SHALL advance by BURST_LEN*8; when ptr+BURST_LEN*8 == FRAME_BYTES, ptr SHALL wrap to 0 and frame_done SHALL pulse 1 cycle.
REQ-026 Write wrap SHALL toggle wr_bank (ping-pong); bank_base = BANK0_ADDR if bank=0 else BANK1_ADDR.
REQ-027 Read wrap SHALL set rd_bank <= ~wr_bank (value after any same-cycle write toggle), so reads always use the last completed frame.
REQ-028 rd_en=0 while not in RD_BUSY SHALL clear rd_ptr to 0; an in-flight read burst SHALL complete normally, then rd_ptr clears.
REQ-029 Write path SHALL run regardless of rd_en.
REQ-030 Pointer arithmetic SHALL be 32-bit unsigned; no overflow past FRAME_BYTES is permitted.

Reset
REQ-031 ARESETN low SHALL asynchronously force IDLE, WR_START=RD_START=0, frame_done pulses=0, wr_ptr=rd_ptr=0, wr_bank=0, rd_bank=1, last_grant=read.
REQ-032 Reset mid-burst SHALL abandon the burst; after release, addresses restart at BANK0_ADDR (write) and BANK1_ADDR (read).
REQ-033 Outputs SHALL be registered; ADRS after reset SHALL show BANK0_ADDR (write) and BANK1_ADDR (read).

Verification
REQ-034 wr_fifo_cnt=64, WR_READY=1, rd_en=0 -> WR_START pulse 1 cycle later, WR_ADRS=0x0, WR_LEN=64; WR_DONE -> next WR_ADRS=0x200.
REQ-035 Both requests pending, both READY -> grants alternate W,R,W,R; never two STARTs without an intervening DONE.
REQ-036 1200 write bursts completed -> wr_frame_done pulses on 1200th DONE, wr_bank=1, next WR_ADRS=0x0010_0000.
REQ-037 rd_fifo_cnt=449 (>448) -> no RD_START; drop to 448 -> RD_START issued; rd_en dropped mid-burst -> burst finishes, next read at RD_ADRS base+0.
REQ-038 Read frame wrap while wr_bank=1 -> rd_bank=0, RD_ADRS=0x0; ARESETN pulse mid WR_BUSY -> all STARTs 0, state IDLE, pointers 0.
